// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a 2-entry input buffer and back-pressure to the
// upstream byte chunker. Data is shifted out LSB first.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WIDTH        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_dv,
  output logic             halt,
  output logic             tx,
  output logic             busy,
  output logic             ovf
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BCNT_RELOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIDX_LAST   = IW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [IW-1:0]    bidx_q, bidx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] buf0_q, buf0_d;
  logic [WIDTH-1:0] buf1_q, buf1_d;

  logic             pop_s;
  logic             push_s;
  logic             bit_end_s;
  logic [1:0]       occ_after_pop_s;

  // Frame sequencer: bit timing, shift register and serial line.
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    bidx_d    = bidx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop_s     = 1'b0;
    bit_end_s = (bcnt_q == {BW{1'b0}});
    case (state_q)
      ST_IDLE: begin
        if (occ_q != 2'd0) begin
          pop_s   = 1'b1;
          shift_d = buf0_q;
          tx_d    = 1'b0;
          bcnt_d  = BCNT_RELOAD;
          state_d = ST_START;
        end else begin
          tx_d = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          tx_d    = shift_q[0];
          bidx_d  = {IW{1'b0}};
          bcnt_d  = BCNT_RELOAD;
          state_d = ST_DATA;
        end else begin
          bcnt_d = bcnt_q - BW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          bcnt_d = BCNT_RELOAD;
          if (bidx_q != BIDX_LAST) begin
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
            bidx_d  = bidx_q + IW'(1);
          end else begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end
        end else begin
          bcnt_d = bcnt_q - BW'(1);
        end
      end
      ST_STOP: begin
        if (bit_end_s && (occ_q != 2'd0)) begin
          // Back-to-back frame: the next start bit follows the stop bit directly.
          pop_s   = 1'b1;
          shift_d = buf0_q;
          tx_d    = 1'b0;
          bcnt_d  = BCNT_RELOAD;
          state_d = ST_START;
        end else if (bit_end_s) begin
          tx_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          bcnt_d = bcnt_q - BW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Input buffer: a pop frees a slot for a push in the same cycle; din is only
  // looked at when it is actually written.
  always_comb begin
    push_s          = din_dv & ((occ_q != 2'd2) | pop_s);
    occ_after_pop_s = occ_q - {1'b0, pop_s};
    occ_d           = occ_after_pop_s + {1'b0, push_s};
    ovf_d           = ovf_q | (din_dv & ~push_s);
    if (pop_s) begin
      buf0_d = buf1_q;
    end else begin
      buf0_d = buf0_q;
    end
    if (push_s && (occ_after_pop_s == 2'd0)) begin
      buf0_d = din;
      buf1_d = buf1_q;
    end else if (push_s) begin
      buf1_d = din;
    end else begin
      buf1_d = buf1_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      bcnt_q  <= {BW{1'b0}};
      bidx_q  <= {IW{1'b0}};
      shift_q <= {WIDTH{1'b0}};
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      occ_q   <= 2'd0;
      buf0_q  <= {WIDTH{1'b0}};
      buf1_q  <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      bidx_q  <= bidx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      occ_q   <= occ_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end

  assign tx   = tx_q;
  assign ovf  = ovf_q;
  assign halt = (occ_q != 2'd0);
  assign busy = (state_q != ST_IDLE) | (occ_q != 2'd0);

endmodule
